// File: rtl/control_clave.sv
// control_clave: four-digit BCD keypad code checker with an independent timer.
// The optional lockout after three consecutive failures is enabled by defining
// the macro CONTROL_CLAVE_BLOQUEO_EN; without it, bloqueo is tied low and
// entry stays allowed with intentos saturated at 3.
module control_clave #(
    parameter logic [15:0] CLAVE     = 16'h1234,
    parameter int          T_CRONO   = 20,
    parameter int          T_BLOQUEO = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_ok,
    input  logic [3:0] tecla,
    input  logic       inicia_crono,
    output logic       pw,
    output logic       pf,
    output logic       ro,
    output logic [1:0] intentos,
    output logic       bloqueo
);

    // Both counters are 8 bits wide, so reject lengths they cannot represent.
    if (T_CRONO < 2 || T_CRONO > 255 || T_BLOQUEO < 2 || T_BLOQUEO > 255) begin : g_param_invalido
        $error("control_clave: T_CRONO and T_BLOQUEO must lie in 2..255");
    end

`ifdef CONTROL_CLAVE_BLOQUEO_EN
    typedef enum logic [1:0] {ESPERA, DIGITOS, EVALUA, BLOQUEO} estado_t;
    localparam logic [7:0] BLOQ_FIN = 8'(T_BLOQUEO - 1);
    logic [7:0] cuenta_bloq_q, cuenta_bloq_d;
`else
    typedef enum logic [1:0] {ESPERA, DIGITOS, EVALUA} estado_t;
`endif

    localparam logic [7:0] CRONO_FIN = 8'(T_CRONO - 1);

    estado_t     estado_q, estado_d;
    logic [1:0]  indice_q, indice_d;
    logic [15:0] registro_q, registro_d;
    logic        pw_q, pw_d;
    logic        pf_q, pf_d;
    logic [1:0]  intentos_q, intentos_d;

    logic [7:0]  crono_q, crono_d;
    logic        crono_activo_q, crono_activo_d;
    logic        ro_q, ro_d;

    // Key FSM: collect digits, compare the full code, track failures and lockout.
    always_comb begin
        estado_d   = estado_q;
        indice_d   = indice_q;
        registro_d = registro_q;
        pw_d       = 1'b0;
        pf_d       = 1'b0;
        intentos_d = intentos_q;
`ifdef CONTROL_CLAVE_BLOQUEO_EN
        cuenta_bloq_d = cuenta_bloq_q;
`endif
        case (estado_q)
            ESPERA, DIGITOS: begin
                if (tecla_ok) begin
                    if (tecla <= 4'd9) begin
                        registro_d = {registro_q[11:0], tecla};
                        indice_d   = indice_q + 2'd1;
                        estado_d   = (indice_q == 2'd3) ? EVALUA : DIGITOS;
                    end else if (tecla == 4'hF) begin
                        indice_d   = 2'd0;
                        registro_d = 16'h0000;
                        estado_d   = ESPERA;
                    end
                end
            end
            EVALUA: begin
                indice_d = 2'd0;
                estado_d = ESPERA;
                if (registro_q == CLAVE) begin
                    pw_d       = 1'b1;
                    intentos_d = 2'd0;
                end else begin
                    pf_d = 1'b1;
                    if (intentos_q != 2'd3) begin
                        intentos_d = intentos_q + 2'd1;
                    end
`ifdef CONTROL_CLAVE_BLOQUEO_EN
                    if (intentos_q == 2'd2) begin
                        estado_d      = BLOQUEO;
                        cuenta_bloq_d = 8'd0;
                    end
`endif
                end
            end
`ifdef CONTROL_CLAVE_BLOQUEO_EN
            BLOQUEO: begin
                if (cuenta_bloq_q == BLOQ_FIN) begin
                    estado_d   = ESPERA;
                    intentos_d = 2'd0;
                end else begin
                    cuenta_bloq_d = cuenta_bloq_q + 8'd1;
                end
            end
`endif
            default: estado_d = ESPERA;
        endcase
    end

    // Key FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= ESPERA;
            indice_q   <= 2'd0;
            registro_q <= 16'h0000;
            pw_q       <= 1'b0;
            pf_q       <= 1'b0;
            intentos_q <= 2'd0;
`ifdef CONTROL_CLAVE_BLOQUEO_EN
            cuenta_bloq_q <= 8'd0;
`endif
        end else begin
            estado_q   <= estado_d;
            indice_q   <= indice_d;
            registro_q <= registro_d;
            pw_q       <= pw_d;
            pf_q       <= pf_d;
            intentos_q <= intentos_d;
`ifdef CONTROL_CLAVE_BLOQUEO_EN
            cuenta_bloq_q <= cuenta_bloq_d;
`endif
        end
    end

    // Timer: a start clears ro and counts edges until T_CRONO is reached, then ro latches high.
    always_comb begin
        crono_d        = crono_q;
        crono_activo_d = crono_activo_q;
        ro_d           = ro_q;
        if (inicia_crono) begin
            crono_d        = 8'd0;
            crono_activo_d = 1'b1;
            ro_d           = 1'b0;
        end else if (crono_activo_q) begin
            crono_d = crono_q + 8'd1;
            if (crono_q == CRONO_FIN) begin
                crono_activo_d = 1'b0;
                ro_d           = 1'b1;
            end
        end
    end

    // Timer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crono_q        <= 8'd0;
            crono_activo_q <= 1'b0;
            ro_q           <= 1'b0;
        end else begin
            crono_q        <= crono_d;
            crono_activo_q <= crono_activo_d;
            ro_q           <= ro_d;
        end
    end

    assign pw       = pw_q;
    assign pf       = pf_q;
    assign ro       = ro_q;
    assign intentos = intentos_q;
`ifdef CONTROL_CLAVE_BLOQUEO_EN
    assign bloqueo  = (estado_q == BLOQUEO);
`else
    assign bloqueo  = 1'b0;
`endif

endmodule

// File: tb/tb_control_clave.sv
// Testbench for control_clave: vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based behavioural model.
module tb_control_clave;

    localparam logic [15:0] CLAVE     = 16'h1234;
    localparam int          T_CRONO   = 20;
    localparam int          T_BLOQUEO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       tecla_ok = 1'b0;
    logic [3:0] tecla = 4'h0;
    logic       inicia_crono = 1'b0;
    logic       pw, pf, ro, bloqueo;
    logic [1:0] intentos;

    int errors = 0;
    int checks = 0;

    control_clave #(.CLAVE(CLAVE), .T_CRONO(T_CRONO), .T_BLOQUEO(T_BLOQUEO)) dut (
        .clk(clk), .rst(rst), .tecla_ok(tecla_ok), .tecla(tecla),
        .inicia_crono(inicia_crono), .pw(pw), .pf(pf), .ro(ro),
        .intentos(intentos), .bloqueo(bloqueo)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int  dig_q[$];
    bit  eval_pend;
    int  lock_left;
    int  fails;
    bit  m_pw, m_pf;
    int  since;

    typedef struct {
        logic       ok;
        logic [3:0] key;
        logic       pw;
        logic       pf;
        logic [1:0] intentos;
    } vec_t;
    vec_t tabla[$];

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        dig_q.delete();
        eval_pend = 0;
        lock_left = 0;
        fails     = 0;
        m_pw      = 0;
        m_pf      = 0;
        since     = -1;
    endtask

    task automatic modelStep(input logic ok, input logic [3:0] key, input logic ini);
        int code;
        m_pw = 0;
        m_pf = 0;
        if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (eval_pend) begin
            code = 0;
            foreach (dig_q[i]) code = code * 16 + dig_q[i];
            if (code == int'(CLAVE)) begin
                m_pw  = 1;
                fails = 0;
            end else begin
                m_pf = 1;
                if (fails < 3) fails++;
`ifdef CONTROL_CLAVE_BLOQUEO_EN
                if (fails == 3) lock_left = T_BLOQUEO;
`endif
            end
            dig_q.delete();
            eval_pend = 0;
        end else if (ok) begin
            if (key <= 4'd9) begin
                dig_q.push_back(int'(key));
                if (dig_q.size() == 4) eval_pend = 1;
            end else if (key == 4'hF) begin
                dig_q.delete();
            end
        end
        if (ini) since = 0;
        else if (since >= 0 && since < T_CRONO) since++;
    endtask

    task automatic checkOutput(input string name);
        compare({name, "_pw"}, 16'(pw), 16'(m_pw));
        compare({name, "_pf"}, 16'(pf), 16'(m_pf));
        compare({name, "_ro"}, 16'(ro), 16'(since >= T_CRONO));
        compare({name, "_intentos"}, 16'(intentos), 16'(fails));
        compare({name, "_bloqueo"}, 16'(bloqueo), 16'(lock_left > 0));
    endtask

    task automatic applyStimulus(input logic ok, input logic [3:0] key, input logic ini);
        tecla_ok     = ok;
        tecla        = key;
        inicia_crono = ini;
        @(posedge clk);
        modelStep(ok, key, ini);
        #1;
        checkOutput("model");
    endtask

    task automatic resetDut();
        tecla_ok     = 1'b0;
        tecla        = 4'h0;
        inicia_crono = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("reset");
        @(posedge clk);
        #1;
        checkOutput("reset_hold");
        rst = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] code);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, code[15-4*i -: 4], 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
    endtask

    task automatic addVec(input logic ok, input logic [3:0] key, input logic epw, input logic epf, input logic [1:0] eint);
        vec_t v;
        v.ok = ok; v.key = key; v.pw = epw; v.pf = epf; v.intentos = eint;
        tabla.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] clave_v;
        logic        ok_r;
        logic [3:0]  key_r;
        logic        ini_r;
        int          s;
        int          r;
        clave_v = CLAVE;

        resetDut();

        // Vector table: correct, wrong, correct, clear mid-entry, ignored key, key during evaluation
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h4, 0, 0, 0);
        addVec(0, 4'h0, 1, 0, 0); addVec(0, 4'h0, 0, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h5, 0, 0, 0);
        addVec(0, 4'h0, 0, 1, 1); addVec(0, 4'h0, 0, 0, 1);
        addVec(1, 4'h1, 0, 0, 1); addVec(1, 4'h2, 0, 0, 1); addVec(1, 4'h3, 0, 0, 1); addVec(1, 4'h4, 0, 0, 1);
        addVec(0, 4'h0, 1, 0, 0); addVec(0, 4'h0, 0, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'hF, 0, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h4, 0, 0, 0);
        addVec(0, 4'h0, 1, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'hB, 0, 0, 0);
        addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h4, 0, 0, 0); addVec(0, 4'h0, 1, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h4, 0, 0, 0);
        addVec(1, 4'h9, 1, 0, 0);
        addVec(1, 4'h1, 0, 0, 0); addVec(1, 4'h2, 0, 0, 0); addVec(1, 4'h3, 0, 0, 0); addVec(1, 4'h4, 0, 0, 0);
        addVec(0, 4'h0, 1, 0, 0);

        foreach (tabla[i]) begin
            applyStimulus(tabla[i].ok, tabla[i].key, 1'b0);
            compare($sformatf("vec%0d_pw", i), 16'(pw), 16'(tabla[i].pw));
            compare($sformatf("vec%0d_pf", i), 16'(pf), 16'(tabla[i].pf));
            compare($sformatf("vec%0d_intentos", i), 16'(intentos), 16'(tabla[i].intentos));
        end

        // Timer: expiry exactly T_CRONO edges after start
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int k = 1; k <= T_CRONO; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0);
            if (k == T_CRONO - 1) compare("ro_before_expiry", 16'(ro), 16'd0);
            if (k == T_CRONO)     compare("ro_at_expiry", 16'(ro), 16'd1);
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        compare("ro_holds", 16'(ro), 16'd1);

        // Timer: restart at edge 10 pushes expiry out
        applyStimulus(1'b0, 4'h0, 1'b1);
        compare("ro_cleared_by_start", 16'(ro), 16'd0);
        for (int k = 1; k < 10; k++) applyStimulus(1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int k = 1; k <= T_CRONO; k++) begin
            applyStimulus(1'b0, 4'h0, 1'b0);
            if (k == T_CRONO - 1) compare("ro_restart_before", 16'(ro), 16'd0);
            if (k == T_CRONO)     compare("ro_restart_expiry", 16'(ro), 16'd1);
        end

        // pw pulse and timer start on the same edge
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, clave_v[15-4*i -: 4], 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1);
        compare("pw_with_start", 16'(pw), 16'd1);
        compare("ro_with_pw_start", 16'(ro), 16'd0);
        for (int k = 1; k <= T_CRONO; k++) applyStimulus(1'b0, 4'h0, 1'b0);
        compare("ro_after_pw_start", 16'(ro), 16'd1);

        // Three consecutive failures
        resetDut();
        enterCode(16'h1235);
        enterCode(16'h9999);
        enterCode(16'h0000);
        compare("intentos_three", 16'(intentos), 16'd3);
`ifdef CONTROL_CLAVE_BLOQUEO_EN
        compare("bloqueo_entered", 16'(bloqueo), 16'd1);
        for (int k = 1; k <= T_BLOQUEO; k++) begin
            applyStimulus(1'b1, clave_v[15-4*(k%4) -: 4], 1'b0);
            if (k == T_BLOQUEO - 1) compare("bloqueo_last_cycle", 16'(bloqueo), 16'd1);
            if (k == T_BLOQUEO - 1) compare("bloqueo_no_pw", 16'(pw), 16'd0);
        end
        compare("bloqueo_released", 16'(bloqueo), 16'd0);
        compare("intentos_after_lock", 16'(intentos), 16'd0);
`else
        compare("bloqueo_tied_low", 16'(bloqueo), 16'd0);
        enterCode(16'h4321);
        compare("intentos_saturated", 16'(intentos), 16'd3);
        compare("pf_at_saturation", 16'(pf), 16'd1);
`endif
        enterCode(CLAVE);
        compare("pw_after_failures", 16'(pw), 16'd1);
        compare("intentos_after_match", 16'(intentos), 16'd0);

        // Reset mid-entry discards the partial code
        applyStimulus(1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0);
        resetDut();
        enterCode(CLAVE);
        compare("pw_after_mid_reset", 16'(pw), 16'd1);

        // Asynchronous reset clears ro before the next edge
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int k = 1; k <= T_CRONO; k++) applyStimulus(1'b0, 4'h0, 1'b0);
        compare("ro_before_async_reset", 16'(ro), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        compare("ro_async_clear", 16'(ro), 16'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("after_async_reset");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                resetDut();
            end else begin
                ok_r  = 1'($urandom_range(0, 1));
                r     = int'($urandom_range(0, 9));
                s     = dig_q.size();
                if (r < 6 && s < 4)  key_r = 4'((clave_v >> (4 * (3 - s))) & 16'hF);
                else if (r < 8)      key_r = 4'($urandom_range(0, 9));
                else                 key_r = 4'($urandom_range(10, 15));
                ini_r = ($urandom_range(0, 39) == 0);
                applyStimulus(ok_r, key_r, ini_r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
